bus_cycle_sequencer: RTL and testbench

Sequential consumer of the memory-control strobes produced by the CPIPE1 control-decode PLA (predecodeEA, pSTOREwrite, pLOADLtobusL, byteEX, storeSXT, RD_WR). It captures the effective address from busL, runs exactly one memory read or write cycle with a ready handshake and wait-state timeout, and stalls the pipeline until the cycle completes. Load data returns to busL, zero- or sign-extended for byte operations.

---
 rtl/bus_cycle_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_bus_cycle_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// bus_cycle_sequencer
//
// Purpose:
//   Consumes the memory-control strobes from the CPIPE1 control-decode PLA.
//   It captures an effective address from busL and runs exactly one memory
//   read or write cycle with a ready handshake and a wait-state timeout. The
//   upstream pipeline is stalled while the cycle is in flight. Load data is
//   returned on busL, zero- or sign-extended for byte operations.
//
// Parameters:
//   MAX_WAIT     - wait cycles allowed with mem_ready low before timeout
//   WAIT_W       - width of the wait counter
//
// Ports:
//   CLK          - clock, all state changes on the rising edge
//   RESET        - asynchronous active-high reset
//   predecodeEA  - busL_in carries an effective address this cycle
//   pSTOREwrite  - store requested (busL_in carries store data in EA cycle)
//   pLOADLtobusL - load requested
//   byteEX       - byte-sized operation, sampled with predecodeEA
//   storeSXT     - sign-extend a byte load, sampled with predecodeEA
//   RD_WR        - decoder read/write level, checked in the EA cycle
//   busL_in      - address or store data
//   mem_rdata    - read data, valid when mem_ready is high in a read
//   mem_ready    - memory completes the current cycle
//   err_clr      - clears bus_err
//   mem_req      - bus cycle active
//   mem_we       - 1 = write cycle
//   mem_byte     - byte cycle
//   mem_addr     - captured effective address
//   mem_wdata    - store data (byte replicated on both lanes for byte stores)
//   busL_out     - load result
//   busL_valid   - one-cycle pulse, busL_out valid
//   stall        - hold upstream pipeline
//   bus_err      - sticky timeout / protocol error flag
// ---------------------------------------------------------------------------
module bus_cycle_sequencer #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        predecodeEA,
    input  logic        pSTOREwrite,
    input  logic        pLOADLtobusL,
    input  logic        byteEX,
    input  logic        storeSXT,
    input  logic        RD_WR,
    input  logic [15:0] busL_in,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        err_clr,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_byte,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] busL_out,
    output logic        busL_valid,
    output logic        stall,
    output logic        bus_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EA   = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(MAX_WAIT);

    state_t            state_q, state_d;
    logic [15:0]       ea_q, ea_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rdResult_q, rdResult_d;
    logic              byte_q, byte_d;
    logic              sxt_q, sxt_d;
    logic              wasRd_q, wasRd_d;
    logic              busErr_q, busErr_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic              errSet;

    // Next-state logic for the sequencer. The EA cycle decides the bus
    // direction (store wins over load) and flags protocol problems without
    // aborting the cycle; a missing strobe is the only case where no bus
    // cycle is run. In RD/WR the wait counter counts cycles with mem_ready
    // low; when it has reached MaxWait and memory still is not ready the
    // cycle is abandoned with an error. A ready in that same last cycle still
    // completes normally because the ready check is taken first.
    always_comb begin
        state_d    = state_q;
        ea_d       = ea_q;
        wdata_d    = wdata_q;
        rdResult_d = rdResult_q;
        byte_d     = byte_q;
        sxt_d      = sxt_q;
        wasRd_d    = wasRd_q;
        waitCnt_d  = waitCnt_q;
        errSet     = 1'b0;

        case (state_q)
            IDLE: begin
                if (predecodeEA) begin
                    ea_d    = busL_in;
                    byte_d  = byteEX;
                    sxt_d   = storeSXT;
                    state_d = EA;
                end
            end
            EA: begin
                waitCnt_d = '0;
                if (pSTOREwrite) begin
                    wdata_d = busL_in;
                    wasRd_d = 1'b0;
                    state_d = WR;
                    if (RD_WR) begin
                        errSet = 1'b1;
                    end
                end else if (pLOADLtobusL) begin
                    wasRd_d = 1'b1;
                    state_d = RD;
                    if (!RD_WR) begin
                        errSet = 1'b1;
                    end
                end else begin
                    errSet  = 1'b1;
                    state_d = IDLE;
                end
            end
            RD: begin
                if (mem_ready) begin
                    if (byte_q) begin
                        rdResult_d = sxt_q ? {{8{mem_rdata[7]}}, mem_rdata[7:0]}
                                           : {8'h00, mem_rdata[7:0]};
                    end else begin
                        rdResult_d = mem_rdata;
                    end
                    state_d = DONE;
                end else if (waitCnt_q == MaxWait) begin
                    errSet  = 1'b1;
                    state_d = IDLE;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            WR: begin
                if (mem_ready) begin
                    state_d = DONE;
                end else if (waitCnt_q == MaxWait) begin
                    errSet  = 1'b1;
                    state_d = IDLE;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new error always wins over a clear arriving in the same cycle.
        if (errSet) begin
            busErr_d = 1'b1;
        end else if (err_clr) begin
            busErr_d = 1'b0;
        end else begin
            busErr_d = busErr_q;
        end
    end

    // State and datapath registers. Reset returns everything, including the
    // captured address and data, to zero so the bus outputs are quiet.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            ea_q       <= '0;
            wdata_q    <= '0;
            rdResult_q <= '0;
            byte_q     <= 1'b0;
            sxt_q      <= 1'b0;
            wasRd_q    <= 1'b0;
            busErr_q   <= 1'b0;
            waitCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ea_q       <= ea_d;
            wdata_q    <= wdata_d;
            rdResult_q <= rdResult_d;
            byte_q     <= byte_d;
            sxt_q      <= sxt_d;
            wasRd_q    <= wasRd_d;
            busErr_q   <= busErr_d;
            waitCnt_q  <= waitCnt_d;
        end
    end

    // Outputs depend only on registered state, so the reset clears them
    // asynchronously and no input reaches an output combinationally.
    // mem_byte is qualified by mem_req so a stale byte flag is not shown
    // while the bus is idle.
    assign mem_req    = (state_q == RD) || (state_q == WR);
    assign mem_we     = (state_q == WR);
    assign mem_byte   = mem_req && byte_q;
    assign mem_addr   = ea_q;
    assign mem_wdata  = byte_q ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q;
    assign busL_out   = rdResult_q;
    assign busL_valid = (state_q == DONE) && wasRd_q;
    assign stall      = (state_q == EA) || (state_q == RD) || (state_q == WR);
    assign bus_err    = busErr_q;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bus_cycle_sequencer
//
// Directed testbench for bus_cycle_sequencer. Inputs are driven 1 time unit
// after each rising edge and outputs are observed at the same point, so each
// observation shows the state entered on the preceding edge.
// ---------------------------------------------------------------------------
module tb_bus_cycle_sequencer;

    logic        CLK;
    logic        RESET;
    logic        predecodeEA;
    logic        pSTOREwrite;
    logic        pLOADLtobusL;
    logic        byteEX;
    logic        storeSXT;
    logic        RD_WR;
    logic [15:0] busL_in;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        err_clr;
    logic        mem_req;
    logic        mem_we;
    logic        mem_byte;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] busL_out;
    logic        busL_valid;
    logic        stall;
    logic        bus_err;

    int vectors;
    int miscompares;

    bus_cycle_sequencer #(
        .MAX_WAIT(15),
        .WAIT_W  (4)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .predecodeEA (predecodeEA),
        .pSTOREwrite (pSTOREwrite),
        .pLOADLtobusL(pLOADLtobusL),
        .byteEX      (byteEX),
        .storeSXT    (storeSXT),
        .RD_WR       (RD_WR),
        .busL_in     (busL_in),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .err_clr     (err_clr),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_byte    (mem_byte),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busL_out    (busL_out),
        .busL_valid  (busL_valid),
        .stall       (stall),
        .bus_err     (bus_err)
    );

    // 10-unit clock period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Single comparison point: counts the vector and reports a miscompare.
    task automatic checkOutput(input string tag, input logic [15:0] got,
                               input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive an EA cycle followed by the strobe cycle; on return the DUT has
    // taken the strobe edge (normally sitting in RD or WR).
    task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] data,
                                 input logic isByte, input logic sxt,
                                 input logic isStore, input logic isLoad,
                                 input logic rdwr);
        predecodeEA  = 1'b1;
        busL_in      = addr;
        byteEX       = isByte;
        storeSXT     = sxt;
        tick();
        predecodeEA  = 1'b0;
        byteEX       = 1'b0;
        storeSXT     = 1'b0;
        busL_in      = data;
        pSTOREwrite  = isStore;
        pLOADLtobusL = isLoad;
        RD_WR        = rdwr;
        tick();
        pSTOREwrite  = 1'b0;
        pLOADLtobusL = 1'b0;
        RD_WR        = 1'b0;
        busL_in      = 16'h0000;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        RESET        = 1'b1;
        predecodeEA  = 1'b0;
        pSTOREwrite  = 1'b0;
        pLOADLtobusL = 1'b0;
        byteEX       = 1'b0;
        storeSXT     = 1'b0;
        RD_WR        = 1'b0;
        busL_in      = 16'h0000;
        mem_rdata    = 16'h0000;
        mem_ready    = 1'b0;
        err_clr      = 1'b0;

        // Reset values.
        repeat (2) tick();
        checkOutput("rst_req",   16'(mem_req),    16'h0);
        checkOutput("rst_stall", 16'(stall),      16'h0);
        checkOutput("rst_addr",  mem_addr,        16'h0000);
        checkOutput("rst_wdata", mem_wdata,       16'h0000);
        checkOutput("rst_busL",  busL_out,        16'h0000);
        checkOutput("rst_err",   16'(bus_err),    16'h0);
        RESET = 1'b0;
        tick();

        // Word load, zero wait states.
        predecodeEA = 1'b1;
        busL_in     = 16'h1234;
        tick();
        checkOutput("wl_ea_stall", 16'(stall),   16'h1);
        checkOutput("wl_ea_req",   16'(mem_req), 16'h0);
        predecodeEA  = 1'b0;
        pLOADLtobusL = 1'b1;
        RD_WR        = 1'b1;
        tick();
        pLOADLtobusL = 1'b0;
        RD_WR        = 1'b0;
        checkOutput("wl_rd_req",  16'(mem_req), 16'h1);
        checkOutput("wl_rd_we",   16'(mem_we),  16'h0);
        checkOutput("wl_rd_addr", mem_addr,     16'h1234);
        mem_ready = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        mem_ready = 1'b0;
        checkOutput("wl_valid", 16'(busL_valid), 16'h1);
        checkOutput("wl_data",  busL_out,        16'hBEEF);
        checkOutput("wl_stall", 16'(stall),      16'h0);
        checkOutput("wl_err",   16'(bus_err),    16'h0);
        tick();
        checkOutput("wl_pulse_end", 16'(busL_valid), 16'h0);

        // Byte load, sign-extended.
        applyStimulus(16'h0010, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("bls_byte", 16'(mem_byte), 16'h1);
        mem_ready = 1'b1;
        mem_rdata = 16'h12F0;
        tick();
        mem_ready = 1'b0;
        checkOutput("bls_data", busL_out, 16'hFFF0);
        tick();

        // Byte load, zero-extended.
        applyStimulus(16'h0011, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        mem_ready = 1'b1;
        mem_rdata = 16'h12F0;
        tick();
        mem_ready = 1'b0;
        checkOutput("blz_data",  busL_out,        16'h00F0);
        checkOutput("blz_valid", 16'(busL_valid), 16'h1);
        tick();

        // Byte store with 3 wait states: 4 WR cycles, ready in the last one.
        applyStimulus(16'h0400, 16'hAB5C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("bs_we",   16'(mem_we),   16'h1);
        checkOutput("bs_byte", 16'(mem_byte), 16'h1);
        checkOutput("bs_addr", mem_addr,      16'h0400);
        for (int i = 0; i < 4; i++) begin
            checkOutput("bs_hold_req",   16'(mem_req), 16'h1);
            checkOutput("bs_hold_wdata", mem_wdata,    16'h5C5C);
            if (i == 3) begin
                mem_ready = 1'b1;
            end
            tick();
        end
        mem_ready = 1'b0;
        checkOutput("bs_done_valid", 16'(busL_valid), 16'h0);
        checkOutput("bs_done_req",   16'(mem_req),    16'h0);
        checkOutput("bs_done_stall", 16'(stall),      16'h0);
        tick();

        // Timeout: 16 RD cycles with no ready.
        applyStimulus(16'h0800, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            checkOutput("to_req", 16'(mem_req), 16'h1);
            tick();
        end
        checkOutput("to_err",   16'(bus_err),    16'h1);
        checkOutput("to_req0",  16'(mem_req),    16'h0);
        checkOutput("to_valid", 16'(busL_valid), 16'h0);
        checkOutput("to_stall", 16'(stall),      16'h0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("to_clr", 16'(bus_err), 16'h0);

        // Ready exactly on the 16th RD cycle completes normally.
        applyStimulus(16'h0802, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                mem_ready = 1'b1;
                mem_rdata = 16'h5555;
            end
            tick();
        end
        mem_ready = 1'b0;
        checkOutput("edge_valid", 16'(busL_valid), 16'h1);
        checkOutput("edge_data",  busL_out,        16'h5555);
        checkOutput("edge_err",   16'(bus_err),    16'h0);
        tick();

        // Neither strobe in EA: back to IDLE with an error, no bus cycle.
        applyStimulus(16'h0900, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("none_req",   16'(mem_req), 16'h0);
        checkOutput("none_stall", 16'(stall),   16'h0);
        checkOutput("none_err",   16'(bus_err), 16'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("none_clr", 16'(bus_err), 16'h0);

        // Both strobes: the write is taken, RD_WR=0 agrees so no error.
        applyStimulus(16'h0A00, 16'h1357, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("both_we",    16'(mem_we), 16'h1);
        checkOutput("both_wdata", mem_wdata,   16'h1357);
        checkOutput("both_err",   16'(bus_err), 16'h0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checkOutput("both_valid", 16'(busL_valid), 16'h0);
        tick();

        // RD_WR disagreeing on a load flags an error but the read proceeds.
        applyStimulus(16'h0B00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("rdwr_err", 16'(bus_err), 16'h1);
        checkOutput("rdwr_req", 16'(mem_req), 16'h1);
        mem_ready = 1'b1;
        mem_rdata = 16'h2468;
        tick();
        mem_ready = 1'b0;
        checkOutput("rdwr_data", busL_out, 16'h2468);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Reset in the middle of a write cycle clears outputs immediately.
        applyStimulus(16'h0C00, 16'hCAFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("mr_req_before", 16'(mem_req), 16'h1);
        #2;
        RESET = 1'b1;
        #1;
        checkOutput("mr_req",   16'(mem_req),    16'h0);
        checkOutput("mr_we",    16'(mem_we),     16'h0);
        checkOutput("mr_stall", 16'(stall),      16'h0);
        checkOutput("mr_addr",  mem_addr,        16'h0000);
        checkOutput("mr_wdata", mem_wdata,       16'h0000);
        checkOutput("mr_valid", 16'(busL_valid), 16'h0);
        #1;
        RESET = 1'b0;
        tick();
        checkOutput("mr_idle_req", 16'(mem_req), 16'h0);

        // Fresh load after reset release.
        applyStimulus(16'h2222, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("fl_addr", mem_addr, 16'h2222);
        mem_ready = 1'b1;
        mem_rdata = 16'h0BAD;
        tick();
        mem_ready = 1'b0;
        checkOutput("fl_valid", 16'(busL_valid), 16'h1);
        checkOutput("fl_data",  busL_out,        16'h0BAD);
        checkOutput("fl_err",   16'(bus_err),    16'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
